sysid_ext: RTL and testbench

SYSID_EXT -- requirements
Module: sysid_ext

---
 rtl/sysid_ext_pkg.sv | 25 ++
 rtl/sysid_ext_uptime.sv | 22 ++
 rtl/sysid_ext.sv | 88 ++++++++
 tb/tb_sysid_ext.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_ext_pkg.sv
// sysid_ext_pkg: register map, CTRL/STATUS bit positions and reset values for sysid_ext.
package sysid_ext_pkg;

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_TS      = 3'd1;
    localparam logic [2:0] ADDR_SCRATCH = 3'd2;
    localparam logic [2:0] ADDR_UP_LO   = 3'd3;
    localparam logic [2:0] ADDR_UP_HI   = 3'd4;
    localparam logic [2:0] ADDR_CTRL    = 3'd5;
    localparam logic [2:0] ADDR_STATUS  = 3'd6;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_CLR_BIT   = 1;
    localparam int STATUS_OVF_BIT = 0;

    localparam logic [31:0] CTRL_RESET = 32'h0000_0001;

    function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? data[8*i +: 8] : old[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/sysid_ext_uptime.sv
// sysid_ext_uptime: 64-bit free-running uptime counter with enable, clear and wrap detect.
module sysid_ext_uptime (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    output logic [63:0] count,
    output logic        wrap
);

    // wrap flags the edge on which all-ones rolls over to zero; a clear suppresses it
    assign wrap = en && !clr && (&count);

    always_ff @(posedge clock or posedge reset)
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 64'd1;

endmodule

// File: rtl/sysid_ext.sv
// sysid_ext: Avalon-MM system ID slave with scratch, control/status and coherent 64-bit uptime.
module sysid_ext
    import sysid_ext_pkg::*;
#(
    parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
    parameter bit          UPTIME_EN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        readdatavalid
);

    logic [31:0] scratch;
    logic [31:0] shadow;
    logic [31:0] rd_mux;
    logic [63:0] count;
    logic        en;
    logic        ovf;
    logic        wrap;
    logic        clr;
    logic        ctrl_wr;
    logic        ovf_clr;

    assign ctrl_wr = write && address == ADDR_CTRL && byteenable[0];
    assign clr     = ctrl_wr && writedata[CTRL_CLR_BIT];
    assign ovf_clr = write && address == ADDR_STATUS && byteenable[0] && writedata[STATUS_OVF_BIT];

    if (UPTIME_EN) begin : g_up
        sysid_ext_uptime u_up (
            .clock(clock),
            .reset(reset),
            .en(en),
            .clr(clr),
            .count(count),
            .wrap(wrap)
        );
    end else begin : g_no_up
        assign count = '0;
        assign wrap  = 1'b0;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:      rd_mux = ID_VALUE;
            ADDR_TS:      rd_mux = TIMESTAMP;
            ADDR_SCRATCH: rd_mux = scratch;
            ADDR_UP_LO:   rd_mux = count[31:0];
            ADDR_UP_HI:   rd_mux = shadow;
            ADDR_CTRL:    rd_mux[CTRL_EN_BIT] = en;
            ADDR_STATUS:  rd_mux[STATUS_OVF_BIT] = ovf;
            default:      rd_mux = '0;
        endcase
    end

    // reading LO snapshots the upper half so a following HI read is coherent with it
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            scratch       <= '0;
            shadow        <= '0;
            en            <= CTRL_RESET[CTRL_EN_BIT];
            ovf           <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read)
                readdata <= rd_mux;
            if (read && address == ADDR_UP_LO)
                shadow <= count[63:32];
            if (write && address == ADDR_SCRATCH)
                scratch <= merge_be(scratch, writedata, byteenable);
            if (ctrl_wr)
                en <= writedata[CTRL_EN_BIT];
            if (wrap)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end

endmodule

// File: tb/tb_sysid_ext.sv
// tb_sysid_ext: scoreboard bench for sysid_ext; expected read data queued at issue, popped on readdatavalid.
module tb_sysid_ext;
    import sysid_ext_pkg::*;

    localparam logic [31:0] ID = 32'h56C4_9E2B;
    localparam logic [31:0] TS = 32'h2024_0611;

    typedef struct packed {
        logic        r;
        logic        w;
        logic [2:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [31:0] e;
    } op_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic [31:0] readdata;
    logic        readdatavalid;

    logic [31:0] exp_q[$];
    logic [31:0] exp;
    logic [31:0] last = '0;
    int          checks = 0;
    int          errors = 0;

    sysid_ext #(.ID_VALUE(ID), .TIMESTAMP(TS), .UPTIME_EN(1'b1)) dut (
        .clock(clock),
        .reset(reset),
        .address(address),
        .read(read),
        .write(write),
        .writedata(writedata),
        .byteenable(byteenable),
        .readdata(readdata),
        .readdatavalid(readdatavalid)
    );

    always #5 clock = ~clock;

    function automatic op_t rd(input logic [2:0] a, input logic [31:0] e);
        return '{1'b1, 1'b0, a, 32'h0, 4'h0, e};
    endfunction

    function automatic op_t wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        return '{1'b0, 1'b1, a, d, be, 32'h0};
    endfunction

    function automatic op_t rw(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be,
                               input logic [31:0] e);
        return '{1'b1, 1'b1, a, d, be, e};
    endfunction

    function automatic op_t nop();
        return '0;
    endfunction

    task automatic step(input op_t o);
        @(negedge clock);
        read       = o.r;
        write      = o.w;
        address    = o.a;
        writedata  = o.d;
        byteenable = o.be;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        read  = 1'b0;
        write = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        last = '0;
    endtask

    task automatic test_reset();
        op_t ops[$];
        @(negedge clock);
        checks++;
        if (readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", readdatavalid);
        end
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 00000000", readdata);
        end
        reset = 1'b0;
        ops = {rd(ADDR_SCRATCH, 32'h0), rd(ADDR_CTRL, 32'h1), rd(ADDR_STATUS, 32'h0),
               rd(ADDR_UP_HI, 32'h0), rd(ADDR_ID, ID), rd(ADDR_TS, TS), rd(3'd7, 32'h0), nop(), nop()};
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                if (readdatavalid !== 1'b1 || readdata !== exp) begin
                    errors++;
                    $display("FAIL reset_map[%0d]: valid=%b data=%h want valid=1 data=%h", i, readdatavalid, readdata, exp);
                end
                last = exp;
            end else if (readdatavalid !== 1'b0 || readdata !== last) begin
                errors++;
                $display("FAIL reset_map_idle[%0d]: valid=%b data=%h want valid=0 data=%h", i, readdatavalid, readdata, last);
            end
            if (ops[i].r) exp_q.push_back(ops[i].e);
        end
    endtask

    task automatic test_scratch();
        op_t ops[$];
        ops = {wr(ADDR_SCRATCH, 32'hFFFF_FFFF, 4'hF), wr(ADDR_SCRATCH, 32'h0000_0012, 4'b0001),
               rd(ADDR_SCRATCH, 32'hFFFF_FF12), rw(ADDR_SCRATCH, 32'hAABB_CCDD, 4'hF, 32'hFFFF_FF12),
               rd(ADDR_SCRATCH, 32'hAABB_CCDD), wr(ADDR_SCRATCH, 32'h5500_0000, 4'b1000),
               wr(ADDR_SCRATCH, 32'h0099_0000, 4'b0000), rd(ADDR_SCRATCH, 32'h55BB_CCDD),
               wr(ADDR_ID, 32'h1234_5678, 4'hF), wr(ADDR_TS, 32'h1234_5678, 4'hF),
               wr(3'd7, 32'hFFFF_FFFF, 4'hF), rd(ADDR_ID, ID), rd(ADDR_TS, TS), rd(3'd7, 32'h0),
               rd(ADDR_SCRATCH, 32'h55BB_CCDD), nop(), nop()};
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                if (readdatavalid !== 1'b1 || readdata !== exp) begin
                    errors++;
                    $display("FAIL scratch[%0d]: valid=%b data=%h want valid=1 data=%h", i, readdatavalid, readdata, exp);
                end
                last = exp;
            end else if (readdatavalid !== 1'b0 || readdata !== last) begin
                errors++;
                $display("FAIL scratch_idle[%0d]: valid=%b data=%h want valid=0 data=%h", i, readdatavalid, readdata, last);
            end
            if (ops[i].r) exp_q.push_back(ops[i].e);
        end
    endtask

    task automatic test_uptime();
        op_t ops[$];
        do_reset();
        for (int k = 0; k < 99; k++) ops.push_back(nop());
        ops.push_back(rd(ADDR_UP_LO, 32'd100));
        ops.push_back(rd(ADDR_UP_HI, 32'h0));
        ops.push_back(rd(ADDR_UP_HI, 32'h0));
        ops.push_back(nop());
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                if (readdatavalid !== 1'b1 || readdata !== exp) begin
                    errors++;
                    $display("FAIL uptime[%0d]: valid=%b data=%h want valid=1 data=%h", i, readdatavalid, readdata, exp);
                end
                last = exp;
            end else if (readdatavalid !== 1'b0 || readdata !== last) begin
                errors++;
                $display("FAIL uptime_idle[%0d]: valid=%b data=%h want valid=0 data=%h", i, readdatavalid, readdata, last);
            end
            if (ops[i].r) exp_q.push_back(ops[i].e);
        end
        @(negedge clock);
        force dut.g_up.u_up.count = 64'h0000_0005_FFFF_FFFE;
        #1 release dut.g_up.u_up.count;
        ops = {rd(ADDR_UP_LO, 32'hFFFF_FFFF), rd(ADDR_UP_HI, 32'h5), rd(ADDR_UP_HI, 32'h5),
               rd(ADDR_UP_LO, 32'h2), rd(ADDR_UP_HI, 32'h6), rd(ADDR_STATUS, 32'h0), nop()};
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                if (readdatavalid !== 1'b1 || readdata !== exp) begin
                    errors++;
                    $display("FAIL shadow[%0d]: valid=%b data=%h want valid=1 data=%h", i, readdatavalid, readdata, exp);
                end
                last = exp;
            end else if (readdatavalid !== 1'b0 || readdata !== last) begin
                errors++;
                $display("FAIL shadow_idle[%0d]: valid=%b data=%h want valid=0 data=%h", i, readdatavalid, readdata, last);
            end
            if (ops[i].r) exp_q.push_back(ops[i].e);
        end
    endtask

    task automatic test_ctrl();
        op_t ops[$];
        do_reset();
        ops = {wr(ADDR_CTRL, 32'h0, 4'hF), rd(ADDR_UP_LO, 32'd2)};
        for (int k = 0; k < 50; k++) ops.push_back(nop());
        ops = {ops, rd(ADDR_UP_LO, 32'd2), rd(ADDR_CTRL, 32'h0), wr(ADDR_CTRL, 32'h3, 4'hF),
               rd(ADDR_UP_LO, 32'd0), rd(ADDR_CTRL, 32'h1), rd(ADDR_UP_LO, 32'd2),
               wr(ADDR_CTRL, 32'h3, 4'hF), rd(ADDR_UP_LO, 32'd0), wr(ADDR_CTRL, 32'hFFFF_FFFD, 4'hF),
               rd(ADDR_CTRL, 32'h1), nop()};
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                if (readdatavalid !== 1'b1 || readdata !== exp) begin
                    errors++;
                    $display("FAIL ctrl[%0d]: valid=%b data=%h want valid=1 data=%h", i, readdatavalid, readdata, exp);
                end
                last = exp;
            end else if (readdatavalid !== 1'b0 || readdata !== last) begin
                errors++;
                $display("FAIL ctrl_idle[%0d]: valid=%b data=%h want valid=0 data=%h", i, readdatavalid, readdata, last);
            end
            if (ops[i].r) exp_q.push_back(ops[i].e);
        end
    endtask

    task automatic test_wrap();
        op_t ops[$];
        do_reset();
        @(negedge clock);
        force dut.g_up.u_up.count = 64'hFFFF_FFFF_FFFF_FFFE;
        #1 release dut.g_up.u_up.count;
        ops = {nop(), rd(ADDR_UP_LO, 32'h0), rd(ADDR_UP_HI, 32'h0), rd(ADDR_STATUS, 32'h1),
               wr(ADDR_CTRL, 32'h3, 4'hF), rd(ADDR_STATUS, 32'h1), wr(ADDR_STATUS, 32'h1, 4'hF),
               rd(ADDR_STATUS, 32'h0), nop()};
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                if (readdatavalid !== 1'b1 || readdata !== exp) begin
                    errors++;
                    $display("FAIL wrap[%0d]: valid=%b data=%h want valid=1 data=%h", i, readdatavalid, readdata, exp);
                end
                last = exp;
            end else if (readdatavalid !== 1'b0 || readdata !== last) begin
                errors++;
                $display("FAIL wrap_idle[%0d]: valid=%b data=%h want valid=0 data=%h", i, readdatavalid, readdata, last);
            end
            if (ops[i].r) exp_q.push_back(ops[i].e);
        end
        @(negedge clock);
        force dut.g_up.u_up.count = 64'hFFFF_FFFF_FFFF_FFFE;
        #1 release dut.g_up.u_up.count;
        ops = {wr(ADDR_STATUS, 32'h1, 4'hF), rd(ADDR_STATUS, 32'h1), rd(ADDR_UP_LO, 32'h1), nop()};
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                if (readdatavalid !== 1'b1 || readdata !== exp) begin
                    errors++;
                    $display("FAIL set_wins[%0d]: valid=%b data=%h want valid=1 data=%h", i, readdatavalid, readdata, exp);
                end
                last = exp;
            end else if (readdatavalid !== 1'b0 || readdata !== last) begin
                errors++;
                $display("FAIL set_wins_idle[%0d]: valid=%b data=%h want valid=0 data=%h", i, readdatavalid, readdata, last);
            end
            if (ops[i].r) exp_q.push_back(ops[i].e);
        end
    endtask

    task automatic test_reset_inflight();
        op_t ops[$];
        ops = {wr(ADDR_SCRATCH, 32'hDEAD_BEEF, 4'hF), wr(ADDR_CTRL, 32'h0, 4'hF),
               rd(ADDR_SCRATCH, 32'hDEAD_BEEF), nop()};
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                if (readdatavalid !== 1'b1 || readdata !== exp) begin
                    errors++;
                    $display("FAIL pre_reset[%0d]: valid=%b data=%h want valid=1 data=%h", i, readdatavalid, readdata, exp);
                end
                last = exp;
            end else if (readdatavalid !== 1'b0 || readdata !== last) begin
                errors++;
                $display("FAIL pre_reset_idle[%0d]: valid=%b data=%h want valid=0 data=%h", i, readdatavalid, readdata, last);
            end
            if (ops[i].r) exp_q.push_back(ops[i].e);
        end
        step(rd(ADDR_SCRATCH, 32'h0));
        #1;
        reset = 1'b1;
        read  = 1'b0;
        @(negedge clock);
        checks++;
        if (readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL inflight_valid: got %b want 0", readdatavalid);
        end
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL inflight_data: got %h want 00000000", readdata);
        end
        reset = 1'b0;
        exp_q.delete();
        last = '0;
        ops = {rd(ADDR_UP_LO, 32'h1), rd(ADDR_SCRATCH, 32'h0), rd(ADDR_CTRL, 32'h1),
               rd(ADDR_STATUS, 32'h0), rd(ADDR_UP_HI, 32'h0), nop()};
        foreach (ops[i]) begin
            step(ops[i]);
            checks++;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                if (readdatavalid !== 1'b1 || readdata !== exp) begin
                    errors++;
                    $display("FAIL post_reset[%0d]: valid=%b data=%h want valid=1 data=%h", i, readdatavalid, readdata, exp);
                end
                last = exp;
            end else if (readdatavalid !== 1'b0 || readdata !== last) begin
                errors++;
                $display("FAIL post_reset_idle[%0d]: valid=%b data=%h want valid=0 data=%h", i, readdatavalid, readdata, last);
            end
            if (ops[i].r) exp_q.push_back(ops[i].e);
        end
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_uptime();
        test_ctrl();
        test_wrap();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        $fatal(1);
    end

endmodule
